mem_stage_sb: RTL and testbench

MEM_STAGE_SB -- requirements
Module: mem_stage_sb

---
 rtl/mem_stage_sb_pkg.sv | 16 +
 rtl/mem_stage_sb_if.sv | 33 +++
 rtl/mem_stage_sb_store_buffer.sv | 82 ++++++++
 rtl/mem_stage_sb.sv | 122 ++++++++++++
 tb/tb_mem_stage_sb.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_sb_pkg.sv
// Shared definitions for the memory stage with store buffer: FSM states and
// default parameter values.
package mem_stage_pkg;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_ADDR_W   = 16;
   localparam int DEF_SB_DEPTH = 4;
   localparam int DEF_MEM_LAT  = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/mem_stage_sb_if.sv
// Request, response and memory-port bundle for the memory stage; slave is
// the stage itself, master is the pipeline/memory side driving it.
interface mem_stage_sb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              is_load;
   logic              is_store;
   logic [ADDR_W-1:0] addr;
   logic              fwd_sel;
   logic [DATA_W-1:0] reg2_data;
   logic [DATA_W-1:0] wb_data;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_data;
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              sb_empty;

   modport slave (
      input  req_valid, is_load, is_store, addr, fwd_sel, reg2_data, wb_data, mem_rdata,
      output req_ready, resp_valid, resp_data, mem_en, mem_wr, mem_addr, mem_wdata, sb_empty
   );

   modport master (
      output req_valid, is_load, is_store, addr, fwd_sel, reg2_data, wb_data, mem_rdata,
      input  req_ready, resp_valid, resp_data, mem_en, mem_wr, mem_addr, mem_wdata, sb_empty
   );
endinterface

// File: rtl/mem_stage_sb_store_buffer.sv
// Circular store FIFO with a youngest-first address lookup used to forward
// buffered store data to loads.
module store_buffer #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enq_i,
   input  logic [ADDR_W-1:0] enq_addr_i,
   input  logic [DATA_W-1:0] enq_data_i,
   input  logic              deq_i,
   input  logic [ADDR_W-1:0] lkp_addr_i,
   output logic              hit_o,
   output logic [DATA_W-1:0] hit_data_o,
   output logic [ADDR_W-1:0] head_addr_o,
   output logic [DATA_W-1:0] head_data_o,
   output logic              full_o,
   output logic              empty_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  head_q;
   logic [PTR_W-1:0]  tail_q;
   logic [CNT_W-1:0]  count_q;
   logic              enq_s;
   logic              deq_s;

   assign full_o      = (count_q == CNT_W'(DEPTH));
   assign empty_o     = (count_q == CNT_W'(0));
   assign enq_s       = enq_i && !full_o;
   assign deq_s       = deq_i && !empty_o;
   assign head_addr_o = addr_q[head_q];
   assign head_data_o = data_q[head_q];

   // Scan oldest to youngest so a younger match overrides any older one.
   always_comb begin
      hit_o      = 1'b0;
      hit_data_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count_q) && (addr_q[head_q + PTR_W'(i)] == lkp_addr_i)) begin
            hit_o      = 1'b1;
            hit_data_o = data_q[head_q + PTR_W'(i)];
         end else begin
            hit_o      = hit_o;
            hit_data_o = hit_data_o;
         end
      end
   end

   // Entry storage, wrapping pointers and occupancy count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (enq_s) begin
            addr_q[tail_q] <= enq_addr_i;
            data_q[tail_q] <= enq_data_i;
            tail_q         <= tail_q + PTR_W'(1);
         end
         if (deq_s) begin
            head_q <= head_q + PTR_W'(1);
         end
         case ({enq_s, deq_s})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mem_stage_sb.sv
// Memory pipeline stage: stores go through a store buffer drained on idle
// port cycles, loads forward from the buffer or wait a fixed read latency.
module mem_stage_sb
   import mem_stage_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int SB_DEPTH = DEF_SB_DEPTH,
   parameter int MEM_LAT  = DEF_MEM_LAT
) (
   input  logic           clk,
   input  logic           rst,
   mem_stage_sb_if.slave  bus
);
   localparam int LAT_W = $clog2(MEM_LAT + 1);

   state_e            state_q;
   logic [LAT_W-1:0]  lat_cnt_q;
   logic              resp_valid_q;
   logic [DATA_W-1:0] resp_data_q;

   logic              ready_s;
   logic              accept_s;
   logic              load_s;
   logic              store_s;
   logic              rd_issue_s;
   logic              drain_s;
   logic              sb_hit_s;
   logic [DATA_W-1:0] sb_hit_data_s;
   logic [ADDR_W-1:0] sb_head_addr_s;
   logic [DATA_W-1:0] sb_head_data_s;
   logic              sb_full_s;
   logic              sb_empty_s;
   logic [DATA_W-1:0] st_data_s;

   assign ready_s    = (state_q == IDLE) && !sb_full_s;
   assign accept_s   = bus.req_valid && ready_s;
   assign load_s     = accept_s && bus.is_load;
   assign store_s    = accept_s && bus.is_store && !bus.is_load;
   assign rd_issue_s = load_s && !sb_hit_s;
   assign drain_s    = !sb_empty_s && !rd_issue_s;
   assign st_data_s  = bus.fwd_sel ? bus.wb_data : bus.reg2_data;

   store_buffer #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (SB_DEPTH)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .enq_i       (store_s),
      .enq_addr_i  (bus.addr),
      .enq_data_i  (st_data_s),
      .deq_i       (drain_s),
      .lkp_addr_i  (bus.addr),
      .hit_o       (sb_hit_s),
      .hit_data_o  (sb_hit_data_s),
      .head_addr_o (sb_head_addr_s),
      .head_data_o (sb_head_data_s),
      .full_o      (sb_full_s),
      .empty_o     (sb_empty_s)
   );

   // Memory port mux: a load-miss read wins the port over a drain write.
   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (rd_issue_s) begin
         bus.mem_en   = 1'b1;
         bus.mem_addr = bus.addr;
      end else if (drain_s) begin
         bus.mem_en    = 1'b1;
         bus.mem_wr    = 1'b1;
         bus.mem_addr  = sb_head_addr_s;
         bus.mem_wdata = sb_head_data_s;
      end else begin
         bus.mem_en = 1'b0;
      end
   end

   // Load FSM with latency down-counter and registered response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         lat_cnt_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load_s && sb_hit_s) begin
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= sb_hit_data_s;
               end else if (rd_issue_s) begin
                  state_q   <= WAIT;
                  lat_cnt_q <= LAT_W'(MEM_LAT - 1);
               end
            end
            WAIT: begin
               if (lat_cnt_q == LAT_W'(0)) begin
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= bus.mem_rdata;
                  state_q      <= RESP;
               end else begin
                  lat_cnt_q <= lat_cnt_q - LAT_W'(1);
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = ready_s;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.sb_empty   = sb_empty_s;

endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed table-driven bench for mem_stage_sb with a fixed-latency memory
// model and a log of every memory write.
module tb_mem_stage_sb;

   typedef struct {
      logic        rv, ld, st;
      logic [15:0] addr;
      logic        fs;
      logic [15:0] r2, wb;
      logic        rdy, men, mwr;
      logic [15:0] maddr, mwd;
      logic        rspv;
      logic [15:0] rspd;
      logic        emp;
   } vec_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   vec_t vecs [$];
   logic [31:0] wr_log [$];
   logic [31:0] exp_log [8];
   logic [1:0]  rd_v;
   logic [15:0] rd_a0, rd_a1;

   mem_stage_sb_if #(.DATA_W(16), .ADDR_W(16)) bus ();

   mem_stage_sb #(
      .DATA_W   (16),
      .ADDR_W   (16),
      .SB_DEPTH (4),
      .MEM_LAT  (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mem_val(input logic [15:0] a);
      case (a)
         16'h0030: mem_val = 16'hBEEF;
         16'h0060: mem_val = 16'h6060;
         16'h0081: mem_val = 16'h8181;
         default:  mem_val = a ^ 16'h5A5A;
      endcase
   endfunction

   // Memory model: read data appears exactly two cycles after issue.
   always @(posedge clk) begin
      rd_v  <= {rd_v[0], bus.mem_en && !bus.mem_wr};
      rd_a0 <= bus.mem_addr;
      rd_a1 <= rd_a0;
      if (bus.mem_en && bus.mem_wr) wr_log.push_back({bus.mem_addr, bus.mem_wdata});
   end
   assign bus.mem_rdata = rd_v[1] ? mem_val(rd_a1) : 16'hDEAD;

   function automatic vec_t v(input logic rv, ld, st, input logic [15:0] a, input logic fs,
                              input logic [15:0] r2, wb, input logic rdy, men, mwr,
                              input logic [15:0] ma, mwd, input logic rspv,
                              input logic [15:0] rd, input logic emp);
      vec_t r;
      r.rv = rv; r.ld = ld; r.st = st; r.addr = a; r.fs = fs; r.r2 = r2; r.wb = wb;
      r.rdy = rdy; r.men = men; r.mwr = mwr; r.maddr = ma; r.mwd = mwd;
      r.rspv = rspv; r.rspd = rd; r.emp = emp;
      return r;
   endfunction

   task automatic drive(input logic rv, ld, st, input logic [15:0] a, input logic fs,
                        input logic [15:0] r2, wb);
      bus.req_valid = rv; bus.is_load = ld; bus.is_store = st; bus.addr = a;
      bus.fwd_sel = fs; bus.reg2_data = r2; bus.wb_data = wb;
   endtask

   task automatic check(input string name, input logic [52:0] exp);
      logic [52:0] act;
      act = {bus.req_ready, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
             bus.resp_valid, bus.resp_data, bus.sb_empty};
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got rdy/en/wr/addr/wdata/rv/rdata/empty=%h required %h", name, act, exp);
      end
   endtask

   localparam logic [52:0] IDLE_OUT_RST = {1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1};

   initial begin
      n_vec = 0;
      n_err = 0;
      exp_log = '{32'h0010_1234, 32'h0020_1111, 32'h0020_2222, 32'h0040_AAAA,
                  32'h0050_0A0A, 32'h0051_0B0B, 32'h0052_0C0C, 32'h0080_8888};
      //              rv   ld   st   addr     fs   r2       wb        rdy  en   wr   maddr    wdata    rv   rdata    emp
      vecs.push_back(v(1'b1,1'b0,1'b1,16'h0010,1'b0,16'h1234,16'h0000, 1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b1));
      vecs.push_back(v(1'b1,1'b1,1'b0,16'h0010,1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b1,16'h0010,16'h1234,1'b0,16'h0000,1'b0));
      vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b1,16'h1234,1'b1));
      vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h1234,1'b1));
      vecs.push_back(v(1'b1,1'b0,1'b1,16'h0020,1'b0,16'h1111,16'h0000, 1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h1234,1'b1));
      vecs.push_back(v(1'b1,1'b0,1'b1,16'h0020,1'b0,16'h2222,16'h0000, 1'b1,1'b1,1'b1,16'h0020,16'h1111,1'b0,16'h1234,1'b0));
      vecs.push_back(v(1'b1,1'b1,1'b0,16'h0020,1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b1,16'h0020,16'h2222,1'b0,16'h1234,1'b0));
      vecs.push_back(v(1'b1,1'b1,1'b0,16'h0030,1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b0,16'h0030,16'h0000,1'b1,16'h2222,1'b1));
      vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h2222,1'b1));
      vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h2222,1'b1));
      vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b1,16'hBEEF,1'b1));
      vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'hBEEF,1'b1));
      vecs.push_back(v(1'b1,1'b0,1'b1,16'h0040,1'b1,16'h5555,16'hAAAA, 1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'hBEEF,1'b1));
      vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b1,16'h0040,16'hAAAA,1'b0,16'hBEEF,1'b0));
      vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'hBEEF,1'b1));
      vecs.push_back(v(1'b1,1'b0,1'b1,16'h0050,1'b0,16'h0A0A,16'h0000, 1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'hBEEF,1'b1));
      vecs.push_back(v(1'b1,1'b1,1'b0,16'h0060,1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b0,16'h0060,16'h0000,1'b0,16'hBEEF,1'b0));
      vecs.push_back(v(1'b1,1'b0,1'b1,16'h0051,1'b0,16'h0B0B,16'h0000, 1'b0,1'b1,1'b1,16'h0050,16'h0A0A,1'b0,16'hBEEF,1'b0));
      vecs.push_back(v(1'b1,1'b0,1'b1,16'h0051,1'b0,16'h0B0B,16'h0000, 1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'hBEEF,1'b1));
      vecs.push_back(v(1'b1,1'b0,1'b1,16'h0051,1'b0,16'h0B0B,16'h0000, 1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b1,16'h6060,1'b1));
      vecs.push_back(v(1'b1,1'b0,1'b1,16'h0051,1'b0,16'h0B0B,16'h0000, 1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h6060,1'b1));
      vecs.push_back(v(1'b1,1'b0,1'b1,16'h0052,1'b0,16'h0C0C,16'h0000, 1'b1,1'b1,1'b1,16'h0051,16'h0B0B,1'b0,16'h6060,1'b0));
      vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b1,16'h0052,16'h0C0C,1'b0,16'h6060,1'b0));
      vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h6060,1'b1));
      vecs.push_back(v(1'b1,1'b0,1'b0,16'h0070,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h6060,1'b1));
      vecs.push_back(v(1'b1,1'b0,1'b1,16'h0080,1'b0,16'h8888,16'h0000, 1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h6060,1'b1));
      vecs.push_back(v(1'b1,1'b1,1'b0,16'h0081,1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b0,16'h0081,16'h0000,1'b0,16'h6060,1'b0));
      vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b1,1'b1,16'h0080,16'h8888,1'b0,16'h6060,1'b0));
      vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h6060,1'b1));
      vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b1,16'h8181,1'b1));
      vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h8181,1'b1));

      // Power-on reset state.
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
      #3;
      check("reset_state", IDLE_OUT_RST);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rv, vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].fs, vecs[i].r2, vecs[i].wb);
         #1;
         check($sformatf("vec%0d", i),
               {vecs[i].rdy, vecs[i].men, vecs[i].mwr, vecs[i].maddr, vecs[i].mwd,
                vecs[i].rspv, vecs[i].rspd, vecs[i].emp});
         @(negedge clk);
      end

      // Reset during WAIT with a store pending drain: everything is discarded.
      drive(1'b1, 1'b0, 1'b1, 16'h0090, 1'b0, 16'h9999, 16'h0000);
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 16'h0030, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
      #1;
      check("wait_drain", {1'b0, 1'b1, 1'b1, 16'h0090, 16'h9999, 1'b0, 16'h8181, 1'b0});
      rst = 1'b0;
      #1;
      check("rst_mid_wait", IDLE_OUT_RST);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         check($sformatf("post_rst%0d", c), IDLE_OUT_RST);
         @(negedge clk);
      end

      // Drained writes in FIFO order; the discarded store never reaches memory.
      n_vec++;
      if (wr_log.size() != 8) begin
         n_err++;
         $display("FAIL wr_log_size: got %0d required %0d", wr_log.size(), 8);
      end
      for (int k = 0; k < 8; k++) begin
         logic [31:0] got;
         got = (k < wr_log.size()) ? wr_log[k] : 32'hFFFF_FFFF;
         n_vec++;
         if (got !== exp_log[k]) begin
            n_err++;
            $display("FAIL wr_log%0d: got addr/data=%h required %h", k, got, exp_log[k]);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
